// File: rtl/uart_tx_framer_if.sv
// Write-side handshake between a word source and the UART transmit framer.
interface uart_tx_framer_if #(
  parameter int unsigned DATA_BITS = 8
);

  logic                 tx_start;
  logic [DATA_BITS-1:0] data_in;
  logic                 tx_ready;

  // Word source: requests a write and watches the holding-register state
  modport master (
    output tx_start,
    output data_in,
    input  tx_ready
  );

  // Framer: accepts words into its holding register
  modport slave (
    input  tx_start,
    input  data_in,
    output tx_ready
  );

endinterface

// File: rtl/uart_tx_framer.sv
// Parametrised UART transmitter: configurable width, optional parity, configurable
// stop length, and a one-word holding register so frames can run back to back.
module uart_tx_framer #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned SB_TICK    = 16,
  parameter int unsigned PARITY     = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              s_tick,
  uart_tx_framer_if.slave   bus,
  output logic              tx_busy,
  output logic              tx,
  output logic              tx_done
);

  localparam int unsigned MAX_TICK = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
  localparam int unsigned TICK_W   = (MAX_TICK > 1) ? $clog2(MAX_TICK) : 1;
  localparam int unsigned BIT_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TICK_W-1:0] BIT_LAST  = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] STOP_LAST = TICK_W'(SB_TICK - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic              HAS_PAR   = (PARITY != 0);
  localparam logic              ODD_PAR   = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e               state_q, state_d;
  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 hold_valid_q, hold_valid_d;
  logic                 tx_q, tx_d;
  logic                 tx_busy_q, tx_busy_d;
  logic                 tx_done_q, tx_done_d;
  logic                 tx_ready_q, tx_ready_d;
  logic                 accept_c;
  logic                 load_c;

  assign accept_c    = bus.tx_start && tx_ready_q;
  assign bus.tx_ready = tx_ready_q;
  assign tx_busy     = tx_busy_q;
  assign tx          = tx_q;
  assign tx_done     = tx_done_q;

  // State and datapath registers; reset aborts any frame and drops the held word
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      tick_q       <= '0;
      bit_q        <= '0;
      shreg_q      <= '0;
      par_q        <= 1'b0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      tx_q         <= 1'b1;
      tx_busy_q    <= 1'b0;
      tx_done_q    <= 1'b0;
      tx_ready_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      bit_q        <= bit_d;
      shreg_q      <= shreg_d;
      par_q        <= par_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      tx_q         <= tx_d;
      tx_busy_q    <= tx_busy_d;
      tx_done_q    <= tx_done_d;
      tx_ready_q   <= tx_ready_d;
    end
  end

  // Next-state, holding-register and registered-output logic
  always_comb begin
    state_d      = state_q;
    tick_d       = tick_q;
    bit_d        = bit_q;
    shreg_d      = shreg_q;
    par_d        = par_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    tx_done_d    = 1'b0;
    load_c       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (hold_valid_q) begin
          load_c = 1'b1;
        end
      end

      S_START: begin
        if (s_tick) begin
          if (tick_q == BIT_LAST) begin
            tick_d  = '0;
            state_d = S_DATA;
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end

      S_DATA: begin
        if (s_tick) begin
          if (tick_q == BIT_LAST) begin
            tick_d  = '0;
            shreg_d = {1'b0, shreg_q[DATA_BITS-1:1]};
            if (bit_q == DATA_LAST) begin
              bit_d   = '0;
              state_d = HAS_PAR ? S_PARITY : S_STOP;
            end else begin
              bit_d = bit_q + BIT_W'(1);
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end

      S_PARITY: begin
        if (s_tick) begin
          if (tick_q == BIT_LAST) begin
            tick_d  = '0;
            state_d = S_STOP;
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end

      S_STOP: begin
        if (s_tick) begin
          if (tick_q == STOP_LAST) begin
            tick_d    = '0;
            tx_done_d = 1'b1;
            if (hold_valid_q) begin
              load_c = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        tick_d  = '0;
        bit_d   = '0;
      end
    endcase

    // Load: move the held word into the shifter; a tick on this clock is dropped
    if (load_c) begin
      shreg_d      = hold_q;
      par_d        = (^hold_q) ^ ODD_PAR;
      hold_valid_d = 1'b0;
      state_d      = S_START;
      tick_d       = '0;
      bit_d        = '0;
    end

    // Accept: only possible while the holding register is empty, so never with a load
    if (accept_c) begin
      hold_d       = bus.data_in;
      hold_valid_d = 1'b1;
    end

    tx_ready_d = !hold_valid_d;
    tx_busy_d  = (state_d != S_IDLE);

    // Line level follows the state being entered so it aligns with tx_done
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer: table-driven frame checks on four
// configurations plus hand-written back-to-back, reset and stalled-tick sequences.
module tb_uart_tx_framer;

  logic       clock = 1'b0;
  logic       reset;
  logic       s_tick;
  logic       tick_en;
  logic       drv_start;
  logic [7:0] drv_data;
  int         sel;
  int         n_tests;
  int         n_fail;

  logic tx0, tx1, tx2, tx3;
  logic busy0, busy1, busy2, busy3;
  logic done0, done1, done2, done3;
  logic obs_tx, obs_busy, obs_done, obs_ready;

  always #5 clock = ~clock;

  uart_tx_framer_if #(.DATA_BITS(8)) if0 ();
  uart_tx_framer_if #(.DATA_BITS(8)) if1 ();
  uart_tx_framer_if #(.DATA_BITS(8)) if2 ();
  uart_tx_framer_if #(.DATA_BITS(7)) if3 ();

  assign if0.tx_start = drv_start && (sel == 0);
  assign if1.tx_start = drv_start && (sel == 1);
  assign if2.tx_start = drv_start && (sel == 2);
  assign if3.tx_start = drv_start && (sel == 3);
  assign if0.data_in  = drv_data;
  assign if1.data_in  = drv_data;
  assign if2.data_in  = drv_data;
  assign if3.data_in  = drv_data[6:0];

  uart_tx_framer #(.DATA_BITS(8), .OVERSAMPLE(16), .SB_TICK(16), .PARITY(0)) u_8n1 (
    .clock(clock), .reset(reset), .s_tick(s_tick), .bus(if0.slave),
    .tx_busy(busy0), .tx(tx0), .tx_done(done0));

  uart_tx_framer #(.DATA_BITS(8), .OVERSAMPLE(16), .SB_TICK(16), .PARITY(1)) u_8e1 (
    .clock(clock), .reset(reset), .s_tick(s_tick), .bus(if1.slave),
    .tx_busy(busy1), .tx(tx1), .tx_done(done1));

  uart_tx_framer #(.DATA_BITS(8), .OVERSAMPLE(16), .SB_TICK(16), .PARITY(2)) u_8o1 (
    .clock(clock), .reset(reset), .s_tick(s_tick), .bus(if2.slave),
    .tx_busy(busy2), .tx(tx2), .tx_done(done2));

  uart_tx_framer #(.DATA_BITS(7), .OVERSAMPLE(16), .SB_TICK(32), .PARITY(0)) u_7n2 (
    .clock(clock), .reset(reset), .s_tick(s_tick), .bus(if3.slave),
    .tx_busy(busy3), .tx(tx3), .tx_done(done3));

  always_comb begin
    obs_tx    = tx0;
    obs_busy  = busy0;
    obs_done  = done0;
    obs_ready = if0.tx_ready;
    case (sel)
      1: begin obs_tx = tx1; obs_busy = busy1; obs_done = done1; obs_ready = if1.tx_ready; end
      2: begin obs_tx = tx2; obs_busy = busy2; obs_done = done2; obs_ready = if2.tx_ready; end
      3: begin obs_tx = tx3; obs_busy = busy3; obs_done = done3; obs_ready = if3.tx_ready; end
      default: ;
    endcase
  end

  // Oversample tick: one clock wide, every 4 clocks, changed just after the rising edge
  initial begin
    int tdiv;
    tdiv   = 0;
    s_tick = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      tdiv   = (tdiv + 1) % 4;
      s_tick = tick_en && (tdiv == 0);
    end
  end

  typedef struct {
    int         sel;
    logic [7:0] data;
    logic [11:0] frame;
    int         nslots;
    int         ticks;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_tx_low(input string name);
    int guard;
    guard = 0;
    while (obs_tx !== 1'b0 && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    check(name, 32'(obs_tx), 32'd0);
  endtask

  task automatic run_frame(input vec_t v, input int idx);
    int c;
    int slot;
    int ticks;
    sel      = v.sel;
    drv_data = v.data;
    @(negedge clock);
    drv_start = 1'b1;
    @(negedge clock);
    drv_start = 1'b0;
    check($sformatf("v%0d_ready_drop", idx), 32'(obs_ready), 32'd0);
    wait_tx_low($sformatf("v%0d_start_bit", idx));
    check($sformatf("v%0d_ready_after_load", idx), 32'(obs_ready), 32'd1);
    check($sformatf("v%0d_busy", idx), 32'(obs_busy), 32'd1);
    c = 0; slot = 0; ticks = 0;
    while (c < 2000) begin
      if (obs_done) break;
      if (s_tick) ticks++;
      if (slot < v.nslots && c == 32 + 64 * slot) begin
        check($sformatf("v%0d_slot%0d", idx, slot), 32'(obs_tx), 32'(v.frame[slot]));
        slot++;
      end
      @(negedge clock);
      c++;
    end
    check($sformatf("v%0d_done_seen", idx), 32'(obs_done), 32'd1);
    check($sformatf("v%0d_slots_sampled", idx), 32'(slot), 32'(v.nslots));
    check($sformatf("v%0d_frame_ticks", idx), 32'(ticks), 32'(v.ticks));
    check($sformatf("v%0d_tx_at_done", idx), 32'(obs_tx), 32'd1);
    @(negedge clock);
    check($sformatf("v%0d_done_width", idx), 32'(obs_done), 32'd0);
    check($sformatf("v%0d_idle_busy", idx), 32'(obs_busy), 32'd0);
    check($sformatf("v%0d_idle_ready", idx), 32'(obs_ready), 32'd1);
    check($sformatf("v%0d_idle_tx", idx), 32'(obs_tx), 32'd1);
    repeat (4) @(negedge clock);
  endtask

  initial begin
    vec_t vecs [5];
    int   dones;
    int   accepts;
    int   dones_at_third;
    int   c;
    logic prev_ready;
    logic activity;

    n_tests   = 0;
    n_fail    = 0;
    sel       = 0;
    drv_start = 1'b0;
    drv_data  = 8'h00;
    tick_en   = 1'b1;
    reset     = 1'b0;

    vecs[0] = '{0, 8'h30, 12'h260, 10, 160};
    vecs[1] = '{1, 8'h35, 12'h46A, 11, 176};
    vecs[2] = '{2, 8'h35, 12'h66A, 11, 176};
    vecs[3] = '{1, 8'h31, 12'h662, 11, 176};
    vecs[4] = '{3, 8'h55, 12'h1AA,  9, 160};

    repeat (3) @(negedge clock);
    for (int s = 0; s < 4; s++) begin
      sel = s;
      #1;
      check($sformatf("rst%0d_tx", s), 32'(obs_tx), 32'd1);
      check($sformatf("rst%0d_ready", s), 32'(obs_ready), 32'd1);
      check($sformatf("rst%0d_busy", s), 32'(obs_busy), 32'd0);
      check($sformatf("rst%0d_done", s), 32'(obs_done), 32'd0);
    end
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    for (int i = 0; i < 5; i++) begin
      run_frame(vecs[i], i);
    end

    // Back-to-back: level-held start streams words with no idle slot between frames
    sel      = 0;
    drv_data = 8'h30;
    @(negedge clock);
    drv_start = 1'b1;
    c = 0;
    while (obs_ready !== 1'b0 && c < 10) begin
      @(negedge clock);
      c++;
    end
    check("b2b_first_accept", 32'(obs_ready), 32'd0);
    drv_data       = 8'h35;
    accepts        = 1;
    dones          = 0;
    dones_at_third = -1;
    prev_ready     = 1'b0;
    c = 0;
    while (dones < 3 && c < 3000) begin
      @(negedge clock);
      c++;
      if (prev_ready && !obs_ready) begin
        accepts++;
        if (accepts == 3) begin
          dones_at_third = dones;
          drv_start = 1'b0;
        end
      end
      prev_ready = obs_ready;
      if (obs_done) begin
        dones++;
        check($sformatf("b2b_tx_at_done%0d", dones), 32'(obs_tx), (dones < 3) ? 32'd0 : 32'd1);
      end
    end
    drv_start = 1'b0;
    check("b2b_done_count", 32'(dones), 32'd3);
    check("b2b_third_accept_after_second_load", 32'(dones_at_third), 32'd1);
    check("b2b_accepts", 32'(accepts), 32'd3);
    repeat (3) @(negedge clock);
    check("b2b_idle_busy", 32'(obs_busy), 32'd0);
    check("b2b_idle_ready", 32'(obs_ready), 32'd1);

    // Reset during data bit 3 with a second word held
    sel      = 0;
    drv_data = 8'h30;
    @(negedge clock);
    drv_start = 1'b1;
    @(negedge clock);
    drv_start = 1'b0;
    wait_tx_low("rm_start_bit");
    drv_data = 8'h35;
    @(negedge clock);
    drv_start = 1'b1;
    @(negedge clock);
    drv_start = 1'b0;
    check("rm_word_held", 32'(obs_ready), 32'd0);
    repeat (283) @(negedge clock);
    check("rm_data_bit3", 32'(obs_tx), 32'd0);
    check("rm_busy_before", 32'(obs_busy), 32'd1);
    reset = 1'b0;
    #1;
    check("rm_tx", 32'(obs_tx), 32'd1);
    check("rm_ready", 32'(obs_ready), 32'd1);
    check("rm_busy", 32'(obs_busy), 32'd0);
    @(negedge clock);
    reset    = 1'b1;
    activity = 1'b0;
    repeat (300) begin
      @(negedge clock);
      if (obs_tx !== 1'b1 || obs_busy !== 1'b0 || obs_done !== 1'b0) activity = 1'b1;
    end
    check("rm_no_restart", 32'(activity), 32'd0);

    // Stalled tick: the frame holds its start bit forever
    tick_en = 1'b0;
    repeat (3) @(negedge clock);
    drv_data = 8'h30;
    drv_start = 1'b1;
    @(negedge clock);
    drv_start = 1'b0;
    repeat (3) @(negedge clock);
    check("nt_tx_low", 32'(obs_tx), 32'd0);
    check("nt_busy", 32'(obs_busy), 32'd1);
    activity = 1'b0;
    repeat (500) begin
      @(negedge clock);
      if (obs_tx !== 1'b0 || obs_done !== 1'b0) activity = 1'b1;
    end
    check("nt_no_advance", 32'(activity), 32'd0);
    check("nt_still_busy", 32'(obs_busy), 32'd1);
    reset = 1'b0;
    @(negedge clock);
    reset   = 1'b1;
    tick_en = 1'b1;
    @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
